// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response pair, with a
// fixed number of wait states between accepting a request and committing it.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge with req_valid && req_ready;
   // a response transfers on a rising edge with rsp_valid && rsp_ready. Neither
   // valid may depend on the matching ready; the response is held until taken.

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [1:0]  cap_size;
   logic        cap_unsigned;
   logic [31:0] cap_wdata;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   // With zero wait states the access commits on the accepting edge itself,
   // so the live request inputs stand in for the captured copy.
   logic        c_we;
   logic [31:0] c_addr;
   logic [1:0]  c_size;
   logic        c_unsigned;
   logic [31:0] c_wdata;
   logic        accept;
   logic        commit;
   logic        c_err;
   logic [IDX_W-1:0] idx;
   logic [4:0]  sh;
   logic [31:0] rd_word;
   logic [31:0] shifted;
   logic [31:0] load_data;
   logic [31:0] lane_mask;
   logic [31:0] rsp_next;

   assign accept     = (state == IDLE) && req_valid;
   assign commit     = reset_n && ((WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd1)));
   assign c_we       = (WAIT_CYCLES == 0) ? req_we       : cap_we;
   assign c_addr     = (WAIT_CYCLES == 0) ? req_addr     : cap_addr;
   assign c_size     = (WAIT_CYCLES == 0) ? req_size     : cap_size;
   assign c_unsigned = (WAIT_CYCLES == 0) ? req_unsigned : cap_unsigned;
   assign c_wdata    = (WAIT_CYCLES == 0) ? req_wdata    : cap_wdata;

   assign idx     = c_addr[IDX_W+1:2];
   assign sh      = {c_addr[1:0], 3'b000};
   assign rd_word = mem[idx];
   assign shifted = rd_word >> sh;

   always_comb begin
      c_err = (c_addr[31:2] >= 30'(DEPTH_WORDS));
      case (c_size)
         2'b01:   if (c_addr[0])          c_err = 1'b1;
         2'b10:   if (c_addr[1:0] != 2'b00) c_err = 1'b1;
         2'b11:   c_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      load_data = rd_word;
      lane_mask = 32'hFFFF_FFFF;
      case (c_size)
         2'b00: begin
            load_data = {{24{~c_unsigned & shifted[7]}}, shifted[7:0]};
            lane_mask = 32'h0000_00FF << sh;
         end
         2'b01: begin
            load_data = {{16{~c_unsigned & shifted[15]}}, shifted[15:0]};
            lane_mask = 32'h0000_FFFF << sh;
         end
         default: ;
      endcase
   end

   assign rsp_next = (c_err || c_we) ? 32'h0 : load_data;

   // Storage has no reset; only committed, error-free stores touch it.
   always_ff @(posedge clk) begin
      if (commit && c_we && !c_err)
         mem[idx] <= (rd_word & ~lane_mask) | ((c_wdata << sh) & lane_mask);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         cap_we       <= 1'b0;
         cap_addr     <= 32'h0;
         cap_size     <= 2'b00;
         cap_unsigned <= 1'b0;
         cap_wdata    <= 32'h0;
         rdata_q      <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we       <= req_we;
                  cap_addr     <= req_addr;
                  cap_size     <= req_size;
                  cap_unsigned <= req_unsigned;
                  cap_wdata    <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state   <= RESP;
                     rdata_q <= rsp_next;
                     err_q   <= c_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state   <= RESP;
                  rdata_q <= rsp_next;
                  err_q   <= c_err;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state   <= IDLE;
                  rdata_q <= 32'h0;
                  err_q   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: round trips, lane writes, misalignment,
// range errors, response backpressure and reset in WAIT/RESP.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
   localparam int WAITC = 2;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one request, scrambles the request bus after the accept, measures
   // the latency to rsp_valid, checks the response, then acknowledges it.
   task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      @(negedge clk);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_size = size; req_unsigned = uns; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~we; req_addr = $urandom;
      req_size = 2'(~size); req_unsigned = ~uns; req_wdata = $urandom;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) break;
      end
      check({tag, "_latency"}, 32'(lat), 32'(WAITC + 1));
      check({tag, "_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      reset_n = 1'b1;

      // Word round trip
      do_req("st_word_10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req("ld_word_10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

      // Byte and half lanes
      do_req("st_word_20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
      do_req("st_byte_21", 1'b1, 32'h21, 2'b00, 1'b0, 32'hFFFFFFAA, 32'h0, 1'b0);
      do_req("ld_sbyte_21", 1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAA, 1'b0);
      do_req("ld_uhalf_20", 1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 32'h0000AA44, 1'b0);
      do_req("ld_word_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0);
      do_req("ld_ubyte_23", 1'b0, 32'h23, 2'b00, 1'b1, 32'h0, 32'h00000011, 1'b0);
      do_req("ld_shalf_22", 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 32'h00001122, 1'b0);
      do_req("st_word_14", 1'b1, 32'h14, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req("st_half_16", 1'b1, 32'h16, 2'b01, 1'b0, 32'h12348001, 32'h0, 1'b0);
      do_req("ld_shalf_16", 1'b0, 32'h16, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);
      do_req("ld_word_14", 1'b0, 32'h14, 2'b10, 1'b1, 32'h0, 32'h80010000, 1'b0);

      // Misalignment
      do_req("ld_word_22", 1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("st_half_23", 1'b1, 32'h23, 2'b01, 1'b0, 32'hBEEF, 32'h0, 1'b1);
      do_req("ld_half_21", 1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("ld_word_20b", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0);

      // Range and illegal size, plus the last valid word
      do_req("ld_oob", 1'b0, 32'(4 * DEPTH), 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("ld_size3", 1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
      do_req("st_last", 1'b1, 32'(4 * DEPTH - 4), 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
      do_req("ld_last", 1'b0, 32'(4 * DEPTH - 4), 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

      // Backpressure: response held, new requests ignored
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (n < 20 && !rsp_valid) begin
         @(negedge clk);
         n++;
      end
      check("bp_latency", 32'(n), 32'(WAITC + 1));
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0;
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rdata", rsp_rdata, 32'h1122AA44);
         check("bp_err", 32'(rsp_err), 32'd0);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_idle_state", 32'(dbg_state), 32'd0);
      check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      do_req("bp_ld_word_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0);

      // Reset in WAIT discards the pending store
      do_req("st_word_30", 1'b1, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_size = 2'b00; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rw_state_wait", 32'(dbg_state), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rw_req_ready", 32'(req_ready), 32'd1);
      check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rw_rdata", rsp_rdata, 32'h0);
      check("rw_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      do_req("rw_ld_word_30", 1'b0, 32'h30, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      do_req("rw_ld_word_10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

      // Reset in RESP drops the response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (n < 20 && !rsp_valid) begin
         @(negedge clk);
         n++;
      end
      check("rr_rdata_before", rsp_rdata, 32'hDEADBEEF);
      reset_n = 1'b0;
      #1;
      check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rr_rdata", rsp_rdata, 32'h0);
      check("rr_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      do_req("rr_ld_word_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h1122AA44, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
